ask4_symbol_scheduler: RTL
==========================

// Module: ask4_symbol_scheduler
// PURPOSE
//  Single-clock scheduler in front of the 4-ASK output stage. Accepts sampler bytes
//  through a valid/ready handshake and buffers them in a small FIFO. Serialises each
//  byte MSB-first into four 2-bit symbols at the symbol rate. Drives a one-hot,
//  carrier-gated level-enable bus to the four DAC level pins.
//  All rate ticks are derived from clk by counters; there are no derived clocks.
// PARAMETERS
//  SYM_DIV     62500  clk cycles per symbol (50 MHz / 62500 = 800 Hz)
//  CAR_DIV     250    clk cycles per carrier half-period (100 kHz carrier)
//  FIFO_DEPTH  4      byte FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1  system clock, 50 MHz
//  rst        in   1  asynchronous reset, active-low
//  enable     in   1  run control; 0 aborts transmission
//  smp_data   in   8  sampler byte
//  smp_valid  in   1  smp_data valid
//  smp_ready  out  1  FIFO can accept; equals ~full
//  sym        out  2  current symbol: 00=1.5V, 01=2.1V, 10=2.7V, 11=3.3V
//  sym_valid  out  1  sym is being transmitted
//  level_en   out  4  one-hot level drive: bit[sym] = carrier while sym_valid, else 0
//  carrier    out  1  free-running square wave, period 2*CAR_DIV clk cycles
//  busy       out  1  state != IDLE
//  underrun   out  1  one-cycle pulse: last symbol of a byte ended with FIFO empty
// BEHAVIOUR
//  Reset values:
//   - sym=0, sym_valid=0, level_en=0, carrier=0, busy=0, underrun=0.
//   - FIFO empty, so smp_ready=1.
//   - All counters 0. State IDLE.
//  FIFO:
//   - Push when smp_valid & smp_ready.
//   - A push while full is ignored, even if a pop happens in the same cycle.
//   - Push and pop in the same cycle (not full) keep the count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - The FIFO accepts pushes while enable=0.
//  Ticks:
//   - sym_tick asserts for one cycle when sym_cnt==SYM_DIV-1; sym_cnt then wraps to 0.
//   - sym_cnt runs only while enable=1 and is held at 0 otherwise.
//   - The carrier toggles every CAR_DIV cycles, independent of enable.
//  FSM IDLE -> SEND -> IDLE:
//   - IDLE -> SEND: on a sym_tick with the FIFO non-empty. Pop the byte into shreg,
//     set sym=shreg[7:6], set sym_valid=1 (registered, visible the cycle after the tick).
//   - SEND, on each sym_tick, when fewer than 4 symbols have been sent:
//     shift shreg left by 2 and present the next pair.
//   - SEND, on the sym_tick after the 4th symbol, with the FIFO non-empty:
//     pop the next byte. No gap between bytes.
//   - SEND, on the sym_tick after the 4th symbol, with the FIFO empty:
//     go to IDLE, sym_valid=0, underrun=1 for one cycle.
//   - enable=0 in any state: go to IDLE on the next clk.
//     * Clear sym_valid, level_en, sym_cnt and the symbol index.
//     * Discard the partially sent byte.
//     * Keep the FIFO contents.
//  Timing:
//   - Latency: a byte pushed into an empty FIFO while IDLE appears as its first symbol
//     at the next sym_tick + 1 clk.
//   - Each symbol lasts exactly SYM_DIV cycles.
//  Output constraints:
//   - level_en is registered. It is never tri-stated and never has more than one bit set.
//   - An asynchronous reset mid-byte returns every output to its reset value immediately.
// CONFIGURATION
//  ASK4_PREAMBLE_EN
//   - Defined:
//     * An IDLE -> SEND transition first emits 4 preamble symbols: 11, 00, 11, 00.
//     * Each preamble symbol lasts SYM_DIV cycles with sym_valid=1.
//     * The FIFO pop happens at the tick that starts the first data symbol.
//     * Back-to-back bytes get no preamble.
//     * enable=0 during the preamble aborts to IDLE.
//   - Undefined: no preamble; data symbols start directly at the first tick.
// TESTING (bench uses SYM_DIV=8, CAR_DIV=2, FIFO_DEPTH=4)
//  1. Reset, enable=1, push 8'hB4 -> sym sequence 10,11,01,00, each 8 cycles;
//     underrun pulses once; busy falls.
//  2. Push 8'h1B and 8'hE4 before the first tick -> 8 symbols 00,01,10,11,11,10,01,00
//     with no gap; a single underrun at the end.
//  3. enable=0, push 5 bytes with smp_valid held high -> smp_ready falls after the 4th;
//     the 5th is ignored; after enable=1, exactly 4 bytes are transmitted.
//  4. During the 2nd symbol of 8'hFF, check level_en == {carrier,3'b000}.
//     Drop enable -> next clk: sym_valid=0, level_en=0; the FIFO count is unchanged.
//  5. Assert rst mid-symbol -> all outputs at reset values in the same cycle;
//     smp_ready=1 after release.
//  6. With ASK4_PREAMBLE_EN, push 8'h00 -> 11,00,11,00,00,00,00,00 (8 symbols),
//     then underrun.

Source files
------------

// File: rtl/ask4_symbol_scheduler.sv
// ask4_symbol_scheduler: byte FIFO + MSB-first 2-bit symbol serialiser for the
// 4-ASK output stage. Drives a one-hot, carrier-gated level-enable bus.
// Optional build macro: ASK4_PREAMBLE_EN (4-symbol 11,00,11,00 preamble before
// each transmission that starts from IDLE).
module ask4_symbol_scheduler #(
  parameter int unsigned SYM_DIV    = 62500,
  parameter int unsigned CAR_DIV    = 250,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] smp_data,
  input  logic       smp_valid,
  output logic       smp_ready,
  output logic [1:0] sym,
  output logic       sym_valid,
  output logic [3:0] level_en,
  output logic       carrier,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned SYM_CW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int unsigned CAR_CW = (CAR_DIV > 1) ? $clog2(CAR_DIV) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [SYM_CW-1:0] SYM_LAST  = SYM_CW'(SYM_DIV - 1);
  localparam logic [CAR_CW-1:0] CAR_LAST  = CAR_CW'(CAR_DIV - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

`ifdef ASK4_PREAMBLE_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_PRE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1} state_e;
`endif

  state_e state_q, state_d;

  // Rate counters
  logic [SYM_CW-1:0] sym_cnt_q, sym_cnt_d;
  logic [CAR_CW-1:0] car_cnt_q, car_cnt_d;
  logic              carrier_q, carrier_d;
  logic              sym_tick;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             ready_q, ready_d;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       rd_data;

  // Serialiser / outputs
  logic [5:0] shreg_q, shreg_d;
  logic [1:0] sym_idx_q, sym_idx_d;
  logic [1:0] sym_q, sym_d;
  logic       sym_valid_q, sym_valid_d;
  logic [3:0] level_en_q, level_en_d;
  logic       busy_q, busy_d;
  logic       underrun_q, underrun_d;
`ifdef ASK4_PREAMBLE_EN
  logic [1:0] pre_idx_q, pre_idx_d;
`endif

  assign smp_ready = ready_q;
  assign sym       = sym_q;
  assign sym_valid = sym_valid_q;
  assign level_en  = level_en_q;
  assign carrier   = carrier_q;
  assign busy      = busy_q;
  assign underrun  = underrun_q;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = smp_valid & ready_q;
  assign rd_data    = mem_q[rd_ptr_q];

  // Free-running carrier and enable-gated symbol-rate counter
  always_comb begin
    car_cnt_d = car_cnt_q + CAR_CW'(1);
    carrier_d = carrier_q;
    if (car_cnt_q == CAR_LAST) begin
      car_cnt_d = '0;
      carrier_d = ~carrier_q;
    end
    sym_tick  = enable && (sym_cnt_q == SYM_LAST);
    sym_cnt_d = sym_cnt_q + SYM_CW'(1);
    if (!enable || sym_tick) begin
      sym_cnt_d = '0;
    end
  end

  // FIFO pointer and occupancy update; a push while full never happens since push needs ready
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    ready_d = (fifo_cnt_d != FIFO_FULL);
  end

  // FSM next-state and serialiser datapath
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    sym_idx_d   = sym_idx_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    underrun_d  = 1'b0;
    pop         = 1'b0;
`ifdef ASK4_PREAMBLE_EN
    pre_idx_d   = pre_idx_q;
`endif

    if (!enable) begin
      state_d     = ST_IDLE;
      sym_valid_d = 1'b0;
      sym_idx_d   = '0;
`ifdef ASK4_PREAMBLE_EN
      pre_idx_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sym_tick && !fifo_empty) begin
`ifdef ASK4_PREAMBLE_EN
            state_d     = ST_PRE;
            pre_idx_d   = '0;
            sym_d       = 2'b11;
            sym_valid_d = 1'b1;
`else
            pop = 1'b1;
`endif
          end
        end
`ifdef ASK4_PREAMBLE_EN
        ST_PRE: begin
          if (sym_tick) begin
            if (pre_idx_q != 2'd3) begin
              // Next preamble symbol alternates 00 after 11 and 11 after 00
              pre_idx_d = pre_idx_q + 2'd1;
              sym_d     = pre_idx_q[0] ? 2'b11 : 2'b00;
            end else if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              sym_valid_d = 1'b0;
            end
          end
        end
`endif
        ST_SEND: begin
          if (sym_tick) begin
            if (sym_idx_q != 2'd3) begin
              sym_d     = shreg_q[5:4];
              shreg_d   = {shreg_q[3:0], 2'b00};
              sym_idx_d = sym_idx_q + 2'd1;
            end else if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              sym_valid_d = 1'b0;
              sym_idx_d   = '0;
              underrun_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          sym_valid_d = 1'b0;
        end
      endcase

      // Loading a byte: MSB pair goes straight out, the rest waits in shreg
      if (pop) begin
        state_d     = ST_SEND;
        sym_d       = rd_data[7:6];
        shreg_d     = rd_data[5:0];
        sym_idx_d   = '0;
        sym_valid_d = 1'b1;
      end
    end

    // Level enable follows next-cycle symbol/carrier so it lines up with sym and carrier
    level_en_d = '0;
    if (sym_valid_d && carrier_d) begin
      level_en_d[sym_d] = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_cnt_q   <= '0;
      car_cnt_q   <= '0;
      carrier_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      ready_q     <= 1'b1;
      shreg_q     <= '0;
      sym_idx_q   <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      level_en_q  <= '0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef ASK4_PREAMBLE_EN
      pre_idx_q   <= '0;
`endif
    end else begin
      sym_cnt_q   <= sym_cnt_d;
      car_cnt_q   <= car_cnt_d;
      carrier_q   <= carrier_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      ready_q     <= ready_d;
      shreg_q     <= shreg_d;
      sym_idx_q   <= sym_idx_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      level_en_q  <= level_en_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
`ifdef ASK4_PREAMBLE_EN
      pre_idx_q   <= pre_idx_d;
`endif
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= smp_data;
    end
  end

endmodule
